// File: rtl/cpu_control_fsm.sv
// Multicycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with a memory-wait watchdog.
// Control outputs are combinational from state, latched class, opcode (DECODE) and mem_ready/zero.
module cpu_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        pc_src,
  output logic [1:0]  alu_op,
  output logic        alu_src_b,
  output logic        mem_to_reg,
  output logic [2:0]  state,
  output logic        halted,
  output logic        bus_error,
  output logic        illegal,
  output logic [15:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] C_R    = 3'd0;
  localparam logic [2:0] C_I    = 3'd1;
  localparam logic [2:0] C_LW   = 3'd2;
  localparam logic [2:0] C_SW   = 3'd3;
  localparam logic [2:0] C_BEQ  = 3'd4;
  localparam logic [2:0] C_BNE  = 3'd5;
  localparam logic [2:0] C_HALT = 3'd6;
  localparam logic [2:0] C_ILL  = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [2:0]  cls_q, cls_d, dec_cls;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] retired_q, retired_d;
  logic        bus_error_q, bus_error_d;
  logic        retire;

  always_comb begin
    case (opcode)
      4'h0:              dec_cls = C_R;
      4'h1, 4'h2, 4'h3:  dec_cls = C_I;
      4'h8:              dec_cls = C_LW;
      4'hB:              dec_cls = C_SW;
      4'h4:              dec_cls = C_BEQ;
      4'h5:              dec_cls = C_BNE;
      4'hF:              dec_cls = C_HALT;
      default:           dec_cls = C_ILL;
    endcase
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    pc_src      = 1'b0;
    alu_op      = 2'b00;
    alu_src_b   = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    retire      = 1'b0;
    state_d     = state_q;
    cls_d       = cls_q;
    bus_error_d = bus_error_q;
    wait_d      = 4'd0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        case (dec_cls)
          C_ILL: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
          C_HALT:  state_d = S_HALT;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_R:  state_d = S_WB;
          C_I: begin
            alu_op    = 2'b01;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          C_LW, C_SW: begin
            alu_op    = 2'b10;
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          C_BEQ, C_BNE: begin
            alu_op = 2'b11;
            // Branches resolve and retire here whether taken or not
            if ((cls_q == C_BEQ) == zero) begin
              pc_write = 1'b1;
              pc_src   = 1'b1;
            end
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        iord      = 1'b1;
        alu_op    = 2'b10;
        mem_read  = (cls_q == C_LW);
        mem_write = (cls_q == C_SW);
        if (mem_ready) begin
          if (cls_q == C_LW) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_LW);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Watchdog: 16 consecutive unanswered memory cycles park the core in HALT
    if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
      if (wait_q == 4'hF) begin
        state_d     = S_HALT;
        bus_error_d = 1'b1;
      end else begin
        wait_d = wait_q + 4'd1;
      end
    end

    retired_d = retire ? retired_q + 16'd1 : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      cls_q       <= C_R;
      wait_q      <= 4'd0;
      retired_q   <= 16'd0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      wait_q      <= wait_d;
      retired_q   <= retired_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign state     = state_q;
  assign bus_error = bus_error_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: instruction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized opcode/zero/mem_ready/reset traffic.
module tb_cpu_control_fsm;

  logic        clk, rst_n, zero, mem_ready;
  logic [3:0]  opcode;
  logic        mem_read, mem_write, iord, ir_write, pc_write, reg_write, pc_src;
  logic [1:0]  alu_op;
  logic        alu_src_b, mem_to_reg, halted, bus_error, illegal;
  logic [2:0]  state;
  logic [15:0] retired;

  cpu_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .mem_to_reg(mem_to_reg), .state(state), .halted(halted),
    .bus_error(bus_error), .illegal(illegal), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_read, mem_write, iord, ir_write, pc_write, reg_write, pc_src;
    logic [1:0] alu_op;
    logic alu_src_b, mem_to_reg;
    logic [2:0] state;
    logic halted, bus_error, illegal;
    logic [15:0] retired;
  } obs_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_HLT = 6, K_ILL = 7;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase number (0..5 as the spec numbers them), opcode seen in DECODE,
  // wait-streak length, retire count and sticky bus error.
  int          m_state;
  logic [3:0]  m_op;
  int          m_wait;
  logic [15:0] m_ret;
  logic        m_berr;

  function automatic int kind(input logic [3:0] op);
    if (op == 4'h0) return K_R;
    if (op >= 4'h1 && op <= 4'h3) return K_I;
    if (op == 4'h8) return K_LW;
    if (op == 4'hB) return K_SW;
    if (op == 4'h4) return K_BEQ;
    if (op == 4'h5) return K_BNE;
    if (op == 4'hF) return K_HLT;
    return K_ILL;
  endfunction

  task automatic model_reset();
    m_state = 0; m_op = 4'h0; m_wait = 0; m_ret = 16'h0; m_berr = 1'b0;
  endtask

  function automatic obs_t expect_out();
    obs_t e = '0;
    int k = kind(m_op);
    e.state     = 3'(m_state);
    e.retired   = m_ret;
    e.bus_error = m_berr;
    case (m_state)
      0: begin
        e.mem_read = 1'b1;
        e.ir_write = mem_ready;
        e.pc_write = mem_ready;
      end
      1: e.illegal = (kind(opcode) == K_ILL);
      2: begin
        e.alu_op    = (k == K_R) ? 2'd0 : (k == K_I) ? 2'd1 : (k == K_LW || k == K_SW) ? 2'd2 : 2'd3;
        e.alu_src_b = (k == K_I || k == K_LW || k == K_SW);
        e.pc_write  = (k == K_BEQ && zero) || (k == K_BNE && !zero);
        e.pc_src    = e.pc_write;
      end
      3: begin
        e.iord = 1'b1; e.alu_op = 2'd2;
        e.mem_read = (k == K_LW); e.mem_write = (k == K_SW);
      end
      4: begin
        e.reg_write = 1'b1; e.mem_to_reg = (k == K_LW);
      end
      5: e.halted = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic model_step();
    int k = kind(m_op);
    int nxt = m_state;
    bit ret = 1'b0;
    case (m_state)
      0: if (mem_ready) nxt = 1;
      1: begin
        m_op = opcode;
        nxt = (kind(opcode) == K_ILL) ? 0 : (kind(opcode) == K_HLT) ? 5 : 2;
      end
      2: if (k == K_BEQ || k == K_BNE) begin ret = 1'b1; nxt = 0; end
         else nxt = (k == K_LW || k == K_SW) ? 3 : 4;
      3: if (mem_ready) begin
           if (k == K_LW) nxt = 4; else begin ret = 1'b1; nxt = 0; end
         end
      4: begin ret = 1'b1; nxt = 0; end
      5: nxt = 5;
      default: nxt = 0;
    endcase
    if ((m_state == 0 || m_state == 3) && !mem_ready) begin
      if (m_wait == 15) begin nxt = 5; m_berr = 1'b1; m_wait = 0; end
      else m_wait = m_wait + 1;
    end else begin
      m_wait = 0;
    end
    if (ret) m_ret = m_ret + 16'd1;
    m_state = nxt;
  endtask

  function automatic obs_t get_obs();
    obs_t g;
    g.mem_read = mem_read; g.mem_write = mem_write; g.iord = iord; g.ir_write = ir_write;
    g.pc_write = pc_write; g.reg_write = reg_write; g.pc_src = pc_src; g.alu_op = alu_op;
    g.alu_src_b = alu_src_b; g.mem_to_reg = mem_to_reg; g.state = state; g.halted = halted;
    g.bus_error = bus_error; g.illegal = illegal; g.retired = retired;
    return g;
  endfunction

  task automatic check_cycle();
    obs_t e = expect_out();
    obs_t g = get_obs();
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL cycle@%0t: outputs got %h expected %h", $time, g, e);
    end
  endtask

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a falling edge: drive, check away from the edge, advance the model on the rise.
  task automatic tick(input logic [3:0] op, input logic z, input logic mr);
    opcode = op; zero = z; mem_ready = mr;
    #1;
    check_cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    lit("rst_state", 16'(state), 16'd0);
    lit("rst_retired", retired, 16'd0);
    lit("rst_bus_error", 16'(bus_error), 16'd0);
    lit("rst_halted", 16'(halted), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0;
    model_reset();
    #2;
    do_reset();

    // R-type, no waits: FETCH, DECODE, EXEC, WB
    lit("r_s0", 16'(state), 16'd0);
    tick(4'h0, 1'b0, 1'b1); lit("r_s1", 16'(state), 16'd1);
    tick(4'h0, 1'b0, 1'b1); lit("r_s2", 16'(state), 16'd2); lit("r_aluop", 16'(alu_op), 16'd0);
    tick(4'h0, 1'b0, 1'b1); lit("r_s4", 16'(state), 16'd4); lit("r_regw", 16'(reg_write), 16'd1);
    tick(4'h0, 1'b0, 1'b1); lit("r_retired", retired, 16'd1); lit("r_back", 16'(state), 16'd0);

    // LW with three MEM wait cycles
    tick(4'h8, 1'b0, 1'b1);
    tick(4'h8, 1'b0, 1'b1);
    tick(4'h8, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      lit("lw_mem_wait", 16'(state), 16'd3);
      lit("lw_iord_rd", 16'({iord, mem_read}), 16'd3);
      tick(4'h8, 1'b0, 1'b0);
    end
    lit("lw_mem_last", 16'(state), 16'd3);
    tick(4'h8, 1'b0, 1'b1);
    lit("lw_wb", 16'(state), 16'd4); lit("lw_m2r", 16'(mem_to_reg), 16'd1);
    tick(4'h8, 1'b0, 1'b1);
    lit("lw_retired", retired, 16'd2);

    // BEQ taken, then BNE not taken, three cycles each
    tick(4'h4, 1'b1, 1'b1); tick(4'h4, 1'b1, 1'b1);
    zero = 1'b1; #1;
    lit("beq_pc", 16'({pc_write, pc_src}), 16'd3);
    tick(4'h4, 1'b1, 1'b1);
    lit("beq_done", 16'(state), 16'd0); lit("beq_ret", retired, 16'd3);
    tick(4'h5, 1'b1, 1'b1); tick(4'h5, 1'b1, 1'b1);
    zero = 1'b1; #1;
    lit("bne_pc", 16'(pc_write), 16'd0);
    tick(4'h5, 1'b1, 1'b1);
    lit("bne_done", 16'(state), 16'd0); lit("bne_ret", retired, 16'd4);

    // Illegal opcode, then HALT opcode
    tick(4'h7, 1'b0, 1'b1);
    opcode = 4'h7; #1;
    lit("ill_pulse", 16'(illegal), 16'd1);
    tick(4'h7, 1'b0, 1'b1);
    lit("ill_fetch", 16'(state), 16'd0); lit("ill_ret", retired, 16'd4);
    tick(4'hF, 1'b0, 1'b1); tick(4'hF, 1'b0, 1'b1);
    lit("halt_op", 16'(state), 16'd5); lit("halt_flag", 16'(halted), 16'd1);
    tick(4'h0, 1'b0, 1'b1);
    lit("halt_stay", 16'(state), 16'd5);
    do_reset();

    // Retire counter wrap
    force dut.retired_q = 16'hFFFF;
    m_ret = 16'hFFFF;
    tick(4'h0, 1'b0, 1'b0);
    release dut.retired_q;
    for (int i = 0; i < 4; i++) tick(4'h0, 1'b0, 1'b1);
    lit("wrap", retired, 16'h0000);

    // Reset in the middle of a SW memory wait
    tick(4'hB, 1'b0, 1'b1); tick(4'hB, 1'b0, 1'b1); tick(4'hB, 1'b0, 1'b1);
    tick(4'hB, 1'b0, 1'b0);
    lit("sw_in_mem", 16'(state), 16'd3);
    do_reset();
    tick(4'hB, 1'b0, 1'b0);

    // FETCH watchdog: 16 waiting FETCH cycles then HALT with bus_error
    do_reset();
    for (int i = 0; i < 16; i++) begin
      lit("wd_fetch", 16'(state), 16'd0);
      tick(4'h0, 1'b0, 1'b0);
    end
    lit("wd_state", 16'(state), 16'd5);
    lit("wd_flags", 16'({halted, bus_error}), 16'd3);
    tick(4'h0, 1'b0, 1'b1); tick(4'h0, 1'b0, 1'b1);
    lit("wd_stay", 16'(state), 16'd5);

    // MEM watchdog on a stalled load
    do_reset();
    tick(4'h8, 1'b0, 1'b1); tick(4'h8, 1'b0, 1'b1); tick(4'h8, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) tick(4'h8, 1'b0, 1'b0);
    lit("wd_mem", 16'({state, bus_error}), 16'({3'd5, 1'b1}));

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ((m_state == 5 && $urandom_range(0, 3) == 0) || $urandom_range(0, 249) == 0)
        do_reset();
      else
        tick(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 75));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port `clk`, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port `opcode`, input, 4 bits: instruction register bits [15:12], valid from the DECODE cycle onward.
REQ-005 SHALL have port `zero`, input, 1 bit: ALU zero flag, sampled in EXEC.
REQ-006 SHALL have port `mem_ready`, input, 1 bit: memory completes the current read/write this cycle.
REQ-007 SHALL have ports `mem_read` and `mem_write`, outputs, 1 bit each: memory strobes.
REQ-008 SHALL have port `iord`, output, 1 bit: memory address select, 0 = PC, 1 = ALU result.
REQ-009 SHALL have ports `ir_write`, `pc_write` and `reg_write`, outputs, 1 bit each: register enables.
REQ-010 SHALL have port `pc_src`, output, 1 bit: PC source, 0 = PC+2, 1 = branch target.
REQ-011 SHALL have port `alu_op`, output, 2 bits, driving alu_control: 00 = type A (R-type, funct decides), 01 = type B (immediate), 10 = type C (address add), 11 = type D (branch compare).
REQ-012 SHALL have ports `alu_src_b` and `mem_to_reg`, outputs, 1 bit each: 1 = immediate, 1 = memory data.
REQ-013 SHALL have port `state`, output, 3 bits: current state encoding.
REQ-014 SHALL have ports `halted`, `bus_error` and `illegal`, outputs, 1 bit each: status flags.
REQ-015 SHALL have port `retired`, output, 16 bits: retired-instruction count.

Function
REQ-016 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to FETCH on the next edge.
REQ-017 FETCH SHALL assert mem_read=1 and iord=0.
  - mem_ready=1: pulse ir_write=1 and pc_write=1 (pc_src=0), next state DECODE.
  - Otherwise: stay in FETCH.
REQ-018 DECODE SHALL latch an instruction class from opcode:
  - 0x0 R
  - 0x1-0x3 I
  - 0x8 LW
  - 0xB SW
  - 0x4 BEQ
  - 0x5 BNE
  - 0xF HALT
  - all other values illegal
REQ-019 DECODE SHALL branch on class:
  - Illegal: pulse illegal=1 for one cycle, next FETCH, retired unchanged.
  - HALT: next HALT.
  - All other classes: next EXEC.
REQ-020 EXEC SHALL drive alu_op by class: R = 00, I = 01, LW/SW = 10, BEQ/BNE = 11; alu_src_b SHALL be 1 for I, LW and SW, else 0.
REQ-021 EXEC for BEQ/BNE SHALL test the branch and then go to FETCH.
  - Taken (zero=1 for BEQ, zero=0 for BNE): pc_write=1, pc_src=1.
  - The instruction retires in this cycle whether taken or not.
REQ-022 EXEC SHALL go to WB for R/I and to MEM for LW/SW.
REQ-023 MEM SHALL hold iord=1 and alu_op=10, with mem_read=1 for LW or mem_write=1 for SW, until mem_ready=1.
  - LW then goes to WB.
  - SW then goes to FETCH and retires.
REQ-024 WB SHALL assert reg_write=1 (mem_to_reg=1 only for LW), retire the instruction and go to FETCH.
REQ-025 Latency from the first FETCH cycle with zero memory wait: R/I = 4 cycles, LW = 5, SW = 4, branch = 3.
REQ-026 A 4-bit wait counter SHALL count consecutive FETCH/MEM cycles with mem_ready=0.
  - It clears on mem_ready=1 and on each state change.
  - If the counter equals 15 and mem_ready=0, the next state is HALT and bus_error is set.
REQ-027 retired SHALL increment by 1 on each retire cycle and wrap from 0xFFFF to 0x0000.
REQ-028 HALT SHALL deassert all strobes and enables and hold halted=1; only reset exits HALT.
REQ-029 Strobe and enable outputs not listed for a state SHALL be 0; alu_op SHALL default to 00 outside EXEC and MEM.

Reset
REQ-030 When rst_n=0, the block SHALL immediately (without waiting for a clock edge) set state=FETCH, wait counter=0, retired=0, bus_error=0 and class=R.
REQ-031 Reset asserted mid-instruction SHALL abandon that instruction without retiring it; the first cycle after reset release SHALL be FETCH with mem_read=1.

Verification
REQ-032 Reset, opcode 0x0, mem_ready held 1 -> states 0,1,2,4; alu_op=00 in EXEC; reg_write in WB; retired=1 after 4 cycles.
REQ-033 Opcode 0x8, mem_ready=0 for 3 MEM cycles then 1 -> MEM lasts 4 cycles with iord=1 and mem_read=1; WB has mem_to_reg=1; retired increments once.
REQ-034 Opcode 0x4 with zero=1, then opcode 0x5 with zero=1 -> first: pc_write=1, pc_src=1 in EXEC; second: pc_write=0 in EXEC; each takes 3 cycles.
REQ-035 mem_ready held 0 in FETCH -> 16 FETCH cycles, then state=5, halted=1, bus_error=1; stays until rst_n=0.
REQ-036 Opcode 0x7 -> illegal pulses in DECODE, next state FETCH, retired unchanged; opcode 0xF -> HALT.
REQ-037 Force retired to 0xFFFF and retire one instruction -> retired=0x0000; assert rst_n=0 during MEM -> state becomes FETCH immediately, with no extra retire.
